fft_r2_iter_engine: RTL and testbench
=====================================

// Module: fft_r2_iter_engine
// PURPOSE
// - Parametrised iterative radix-2 DIT FFT. Buffers one frame of N real audio samples, transforms in place, streams N complex bins out.
// - Sits between the audio sample capture path and the spectrum/bar renderer; generalises the fixed 16-point FFT in the visualizer.
// - One butterfly per clock; valid/ready on both sides.
// PARAMETERS
// - N_POINTS  16  transform length; power of two, 4..256
// - DATA_W    16  signed input sample / output bin component width
// - TW_W      16  signed twiddle width, Q1.(TW_W-1)
// - LOG2N     $clog2(N_POINTS)  derived; do not override
// PORTS
// - clk        in   1             clock
// - reset      in   1             asynchronous, active-high reset
// - in_valid   in   1             input sample valid
// - in_ready   out  1             engine accepts a sample this cycle
// - in_data    in   DATA_W        signed real sample (imag = 0)
// - out_valid  out  1             output bin valid
// - out_ready  in   1             downstream accepts bin
// - out_re     out  DATA_W        bin real part, saturated
// - out_im     out  DATA_W        bin imag part, saturated
// - out_idx    out  LOG2N         bin index k, natural order 0..N-1
// - out_last   out  1             high with bin N-1
// - busy       out  1             high in COMPUTE or OUTPUT
// BEHAVIOUR
// - Reset (async, active-high): state=LOAD, all counters 0; in_ready=1, out_valid=0, out_last=0, busy=0, out_re/im/idx=0. Buffer contents undefined.
// - FSM LOAD->COMPUTE->OUTPUT->LOAD. No halt state.
// - LOAD: in_ready=1; in_valid&in_ready writes sample n to buffer addr bitrev(n), imag=0, n++. On n=N-1 accept -> COMPUTE next cycle, in_ready=0.
// - COMPUTE: stage s=0..LOG2N-1, butterfly j=0..N/2-1, one per cycle; exactly LOG2N*N/2 cycles, then OUTPUT.
// - Butterfly: t=b*W^k, W^k=cos(2pi k/N)-j*sin(2pi k/N), k=(j mod 2^s)*(N>>(s+1)).
// - Twiddle ROM of N/2 entries built at elaboration, round-to-nearest to TW_W.
// - Product is full width, rounded by adding 2^(TW_W-2), then >>>(TW_W-1).
// - a'=(a+t)>>>1, b'=(a-t)>>>1, floor shift; every stage scales by 1/2, so total output = X[k]/N.
// - Internal storage IW=DATA_W+2 per component; no internal wrap.
// - OUTPUT: out_valid=1 with bin k in natural order. Advance only on out_valid&out_ready.
// - While out_ready=0, all out_* are held stable.
// - Accept of k=N-1 (out_last=1) -> LOAD next cycle, out_valid=0.
// - Output saturation: components outside DATA_W signed range clamp to +2^(DATA_W-1)-1 / -2^(DATA_W-1).
// - Latency: last input accept to first out_valid = LOG2N*N/2+1 cycles.
// - in_valid outside LOAD is ignored (not accepted, no error). out_ready outside OUTPUT is ignored.
// - Reset mid-frame: partial frame discarded; first cycle after release is LOAD with n=0.
// CONFIGURATION
// - FFT_MAG_EN defined: adds port out_mag out DATA_W+1.
//   - out_mag=|re|+|im| of the saturated bin, unsigned, registered and aligned with out_re/out_im.
//   - out_mag reset value 0.
// - FFT_MAG_EN undefined: out_mag port and its logic are absent; all other behaviour is identical.
// TESTING (N_POINTS=16, DATA_W=16, TW_W=16)
// - Impulse x[0]=16384, rest 0 -> all 16 bins re=1024, im=0 (+-1); out_last only on k=15.
// - DC all x[n]=1000 -> bin0 re=1000 (+-1); bins 1..15 |re|,|im|<=1.
// - x[n]=round(8192*cos(2pi*2n/16)) -> bins 2 and 14 re=4096 (+-2); all other components |.|<=2.
// - Timing: in_valid=1 continuously -> in_ready falls after 16th accept; first out_valid exactly 33 cycles later.
// - Backpressure: out_ready=0 for 5 cycles while k=3 presented -> out_re/out_im/out_idx=3 held stable; 16 bins total, none lost or duplicated.
// - Reset mid-COMPUTE and mid-OUTPUT -> after release in_ready=1, out_valid=0, busy=0; next full frame transforms correctly.
// - FFT_MAG_EN with the cosine test -> out_mag=4096 (+-3) at k=2 and k=14.

Source files
------------

// File: rtl/fft_r2_iter_engine.sv
// Iterative in-place radix-2 DIT FFT: loads N real samples bit-reversed, one butterfly
// per clock, streams N bins in natural order. Define FFT_MAG_EN to add the out_mag port.
module fft_r2_iter_engine #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16,
  parameter int LOG2N    = $clog2(N_POINTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy
`ifdef FFT_MAG_EN
  ,
  output logic [DATA_W:0]          out_mag
`endif
);
  localparam int  IW       = DATA_W + 2;
  localparam int  HALF     = N_POINTS / 2;
  localparam int  JW       = LOG2N - 1;
  localparam int  SW       = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int  PW       = IW + TW_W + 1;
  localparam real PI       = 3.14159265358979323846;
  localparam real TW_SCALE = 2.0 ** (TW_W - 1);
  localparam int  TW_MAX   = (1 << (TW_W - 1)) - 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 2);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_e;

  state_e                   state_q, state_d;
  logic [LOG2N-1:0]         n_q, n_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [JW-1:0]            j_q, j_d;
  logic                     in_ready_q, in_ready_d, busy_q, busy_d;
  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [DATA_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [LOG2N-1:0]         out_idx_q, out_idx_d;
  logic signed [IW-1:0]     buf_re_q [N_POINTS];
  logic signed [IW-1:0]     buf_im_q [N_POINTS];

  // W^k = cos - j*sin, rounded to nearest; cos(0)=+1 clamps to the largest Q1 code.
  logic signed [TW_W-1:0] tw_re [HALF];
  logic signed [TW_W-1:0] tw_im [HALF];
  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam real ANG   = 2.0 * PI * g / N_POINTS;
    localparam int  COS_I = int'($cos(ANG) * TW_SCALE);
    localparam int  SIN_I = int'(-$sin(ANG) * TW_SCALE);
    localparam int  COS_C = (COS_I > TW_MAX) ? TW_MAX : COS_I;
    localparam int  SIN_C = (SIN_I > TW_MAX) ? TW_MAX : SIN_I;
    assign tw_re[g] = TW_W'(COS_C);
    assign tw_im[g] = TW_W'(SIN_C);
  end

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [IW-1:0] x);
    if ((&x[IW-1:DATA_W-1]) || !(|x[IW-1:DATA_W-1])) return x[DATA_W-1:0];
    return x[IW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  logic [LOG2N-1:0]     bf_mask, bf_low, bf_top, bf_bot, ld_addr, rd_idx;
  logic [JW-1:0]        bf_k;
  logic signed [IW-1:0] a_re, a_im, b_re, b_im, na_re, na_im, nb_re, nb_im;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [IW+1:0] t_re, t_im, s_re, s_im, d_re, d_im;
  logic                 ld_we, bf_we, out_load;

  // Butterfly j of stage s pairs (top, top + 2^s); both halves written back in place.
  always_comb begin
    bf_mask = (LOG2N'(1) << stage_q) - LOG2N'(1);
    bf_low  = {1'b0, j_q} & bf_mask;
    bf_top  = (({1'b0, j_q} & ~bf_mask) << 1) | bf_low;
    bf_bot  = bf_top | (LOG2N'(1) << stage_q);
    bf_k    = JW'(bf_low << (SW'(LOG2N - 1) - stage_q));
    a_re    = buf_re_q[bf_top];
    a_im    = buf_im_q[bf_top];
    b_re    = buf_re_q[bf_bot];
    b_im    = buf_im_q[bf_bot];
    p_re    = PW'(b_re) * PW'(tw_re[bf_k]) - PW'(b_im) * PW'(tw_im[bf_k]) + RND;
    p_im    = PW'(b_re) * PW'(tw_im[bf_k]) + PW'(b_im) * PW'(tw_re[bf_k]) + RND;
    t_re    = (IW+2)'(p_re >>> (TW_W - 1));
    t_im    = (IW+2)'(p_im >>> (TW_W - 1));
    s_re    = (IW+2)'(a_re) + t_re;
    s_im    = (IW+2)'(a_im) + t_im;
    d_re    = (IW+2)'(a_re) - t_re;
    d_im    = (IW+2)'(a_im) - t_im;
    na_re   = IW'(s_re >>> 1);
    na_im   = IW'(s_im >>> 1);
    nb_re   = IW'(d_re >>> 1);
    nb_im   = IW'(d_im >>> 1);
    ld_addr = '0;
    for (int i = 0; i < LOG2N; i++) ld_addr[i] = n_q[LOG2N-1-i];
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a presented output bin stays frozen until it is taken.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    stage_d     = stage_q;
    j_d         = j_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    ld_we       = 1'b0;
    bf_we       = 1'b0;
    out_load    = 1'b0;
    rd_idx      = '0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          ld_we = 1'b1;
          n_d   = n_q + LOG2N'(1);
          if (n_q == LOG2N'(N_POINTS - 1)) begin
            n_d        = '0;
            state_d    = ST_COMPUTE;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        bf_we = 1'b1;
        j_d   = j_q + JW'(1);
        if (j_q == JW'(HALF - 1)) begin
          j_d     = '0;
          stage_d = stage_q + SW'(1);
          if (stage_q == SW'(LOG2N - 1)) begin
            stage_d = '0;
            state_d = ST_OUTPUT;
          end
        end
      end
      ST_OUTPUT: begin
        if (!out_valid_q) begin
          out_load = 1'b1;
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
          end else begin
            out_load = 1'b1;
            rd_idx   = out_idx_q + LOG2N'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (out_load) begin
      out_valid_d = 1'b1;
      out_idx_d   = rd_idx;
      out_last_d  = (rd_idx == LOG2N'(N_POINTS - 1));
      out_re_d    = sat(buf_re_q[rd_idx]);
      out_im_d    = sat(buf_im_q[rd_idx]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      n_q         <= '0;
      stage_q     <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) begin
      buf_re_q[ld_addr] <= IW'(in_data);
      buf_im_q[ld_addr] <= '0;
    end
    if (bf_we) begin
      buf_re_q[bf_top] <= na_re;
      buf_im_q[bf_top] <= na_im;
      buf_re_q[bf_bot] <= nb_re;
      buf_im_q[bf_bot] <= nb_im;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

`ifdef FFT_MAG_EN
  function automatic logic [DATA_W:0] mag_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] e;
    e = {x[DATA_W-1], x};
    return x[DATA_W-1] ? $unsigned(-e) : $unsigned(e);
  endfunction

  logic [DATA_W:0] out_mag_q, out_mag_d;

  always_comb begin
    out_mag_d = out_mag_q;
    if (out_load) out_mag_d = mag_abs(out_re_d) + mag_abs(out_im_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_mag_q <= '0;
    else       out_mag_q <= out_mag_d;
  end

  assign out_mag = out_mag_q;
`endif
endmodule

// File: tb/tb_fft_r2_iter_engine.sv
// Directed + randomized bench for fft_r2_iter_engine (N=16) against a direct-DFT reference
// model; define FFT_MAG_EN to also check out_mag.
module tb_fft_r2_iter_engine;
  localparam int  N  = 16;
  localparam int  DW = 16;
  localparam int  LG = 4;
  localparam real PI = 3.14159265358979323846;

  logic                 clk, reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_data, out_re, out_im;
  logic [LG-1:0]        out_idx;
`ifdef FFT_MAG_EN
  logic [DW:0]          out_mag;
`endif

  int            checks, errors;
  int            cyc = 0;
  int            last_acc_cyc;
  int            frame_x [N];
  logic [DW-1:0] exp_re_q [$];
  logic [DW-1:0] exp_im_q [$];

  fft_r2_iter_engine #(.N_POINTS(N), .DATA_W(DW), .TW_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
`ifdef FFT_MAG_EN
    ,
    .out_mag  (out_mag)
`endif
  );

  // Clock, cycle counter and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv, input int tol);
    logic signed [31:0] diff;
    checks++;
    diff = obs - expv;
    assert (((diff <= tol) && (diff >= -tol)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag, obs, expv, tol);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: X[k]/N by direct DFT in real arithmetic, rounded and saturated.
  task automatic model_frame();
    real acc_re, acc_im, ang;
    for (int k = 0; k < N; k++) begin
      acc_re = 0.0;
      acc_im = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * real'((k * n) % N) / real'(N);
        acc_re = acc_re + real'(frame_x[n]) * $cos(ang);
        acc_im = acc_im - real'(frame_x[n]) * $sin(ang);
      end
      exp_re_q.push_back(DW'(sat16(int'(acc_re / real'(N)))));
      exp_im_q.push_back(DW'(sat16(int'(acc_im / real'(N)))));
    end
  endtask

  task automatic fill_random(input int amp);
    for (int n = 0; n < N; n++) frame_x[n] = int'($urandom_range(0, 2 * amp)) - amp;
  endtask

  // Driver: presents frame_x; ends at the negedge after the final accept.
  task automatic send_frame(input bit gaps, input bit hold_valid);
    int n, guard;
    n = 0;
    guard = 0;
    while (n < N && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(frame_x[n]);
        if (in_ready === 1'b1) n++;
      end
    end
    chk("samples_sent", n, N);
    @(negedge clk);
    last_acc_cyc = cyc;
    if (!hold_valid) in_valid = 1'b0;
    chk("in_ready_low_after_frame", in_ready, 0);
    chk("busy_after_frame", busy, 1);
  endtask

  // Scoreboard consumer: pops one expected bin per accepted handshake.
  task automatic collect_frame(input int tol, input bit rand_ready, input bit bp_at3);
    int                   k, guard, held, ire, iim;
    logic signed [DW-1:0] er, ei;
    bit                   go;
    k = 0;
    guard = 0;
    held = 0;
    while (k < N && guard < 3000) begin
      @(negedge clk);
      guard++;
      out_ready = 1'b0;
      if (out_valid === 1'b1) begin
        go = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bp_at3 && k == 3 && held < 5) begin
          go = 1'b0;
          held++;
          chk("bp_hold_idx", out_idx, 3);
          chk_tol("bp_hold_re", out_re, signed'(exp_re_q[0]), tol);
          chk_tol("bp_hold_im", out_im, signed'(exp_im_q[0]), tol);
        end
        if (go) begin
          er = exp_re_q.pop_front();
          ei = exp_im_q.pop_front();
          chk("bin_idx", out_idx, k);
          chk_tol("bin_re", out_re, er, tol);
          chk_tol("bin_im", out_im, ei, tol);
          chk("bin_last", out_last, (k == N - 1));
`ifdef FFT_MAG_EN
          ire = er;
          iim = ei;
          chk_tol("bin_mag", {15'b0, out_mag}, (ire < 0 ? -ire : ire) + (iim < 0 ? -iim : iim),
                  (tol == 2) ? 3 : 2 * tol + 1);
`endif
          out_ready = 1'b1;
          k++;
        end
      end
    end
    chk("bins_collected", k, N);
    @(negedge clk);
    out_ready = 1'b0;
    check_idle("after_output");
  endtask

  initial begin
    int guard;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_idle("reset");
    chk("reset_out_last", out_last, 0);
    chk("reset_out_re", out_re, 0);
    chk("reset_out_im", out_im, 0);
    chk("reset_out_idx", out_idx, 0);

    // Impulse with in_valid held high throughout: in_ready drop and 33-cycle latency
    for (int n = 0; n < N; n++) frame_x[n] = (n == 0) ? 16384 : 0;
    model_frame();
    send_frame(1'b0, 1'b1);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      chk("in_ready_low_during_compute", in_ready, 0);
      guard++;
    end
    chk("first_out_latency", cyc - last_acc_cyc, 33);
    in_valid = 1'b0;
    collect_frame(1, 1'b0, 1'b0);

    // DC 1000 with input gaps and random output stalls
    for (int n = 0; n < N; n++) frame_x[n] = 1000;
    model_frame();
    send_frame(1'b1, 1'b0);
    collect_frame(1, 1'b1, 1'b0);

    // Cosine at bin 2, with a 5-cycle stall while k=3 is presented
    for (int n = 0; n < N; n++) frame_x[n] = int'(8192.0 * $cos(2.0 * PI * 2.0 * n / 16.0));
    model_frame();
    send_frame(1'b0, 1'b0);
    collect_frame(2, 1'b0, 1'b1);

    // Full-scale negative DC
    for (int n = 0; n < N; n++) frame_x[n] = -32768;
    model_frame();
    send_frame(1'b0, 1'b0);
    collect_frame(2, 1'b0, 1'b0);

    // Reset mid-COMPUTE
    fill_random(20000);
    send_frame(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    apply_reset();
    check_idle("reset_mid_compute");

    // Reset mid-OUTPUT
    fill_random(20000);
    send_frame(1'b0, 1'b0);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_output_reached", out_valid, 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    apply_reset();
    check_idle("reset_mid_output");
    chk("reset_mid_output_idx", out_idx, 0);
    chk("reset_mid_output_re", out_re, 0);

    // Random frames
    for (int r = 0; r < 4; r++) begin
      fill_random(30000);
      model_frame();
      send_frame(1'b1, 1'b0);
      collect_frame(6, 1'b1, 1'b0);
    end

    chk("exp_queue_empty", exp_re_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
